// File: rtl/gauge_pkg.sv
// Shared types and elaboration-time helpers for the dashboard gauge driver.
// POS_W sizes every needle position; the top's STEPS_FULL must not exceed 2**POS_W.
package gauge_pkg;

  typedef enum logic [1:0] {
    HOME   = 2'd0,
    SETTLE = 2'd1,
    TRACK  = 2'd2
  } axis_state_t;

  localparam int STEPS_FULL_DEF = 1024;
  localparam int POS_W          = $clog2(STEPS_FULL_DEF);

  // Q16 gain so that full_scale input units map onto steps positions.
  function automatic logic [31:0] gain_q16(input int unsigned steps, input int unsigned full_scale);
    logic [63:0] num;
    num = {32'd0, steps} << 16;
    return 32'(num / {32'd0, full_scale});
  endfunction

endpackage

// File: rtl/dashboard_gauge_driver_if.sv
// Producer-to-consumer bundle carrying engine speed and vehicle speed.
// Valid/ready semantics: none needed; the consumer samples both values whenever it likes.
interface dashboard_gauge_driver_if;
  logic [13:0] engine_rev;
  logic [8:0]  vehicle_speed;

  modport master (output engine_rev, output vehicle_speed);
  modport slave  (input  engine_rev, input  vehicle_speed);
endinterface

// File: rtl/gauge_axis.sv
// One stepper needle: homes against the end stop, settles, then slews toward target
// at no more than one step per slot, with dir set up a clock ahead of each step edge.
module gauge_axis
  import gauge_pkg::*;
#(
    parameter int STEPS_FULL  = STEPS_FULL_DEF,
    parameter int STEP_CLKS   = 50_000,
    parameter int HOME_MARGIN = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [POS_W-1:0] target,
    output logic             step,
    output logic             dir,
    output logic             tracking,
    output axis_state_t      state_dbg
);

    localparam int HALF       = STEP_CLKS / 2;
    localparam int SLOT_W     = $clog2(STEP_CLKS);
    localparam int HOME_STEPS = STEPS_FULL + HOME_MARGIN;
    localparam int HOME_W     = $clog2(HOME_STEPS + 1);
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(STEPS_FULL - 1);

    axis_state_t       state, state_n;
    logic [SLOT_W-1:0] slot_cnt, slot_next;
    logic [POS_W-1:0]  pos, pos_n;
    logic [HOME_W-1:0] home_cnt, home_n;
    logic              active, active_n;
    logic              dir_n, step_n;
    logic              slot_last, slot_fall;

    assign slot_last = (slot_cnt == SLOT_W'(STEP_CLKS - 1));
    assign slot_fall = (slot_cnt == SLOT_W'(HALF));
    assign slot_next = slot_last ? '0 : slot_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= HOME;
            slot_cnt <= '0;
            pos      <= '0;
            home_cnt <= '0;
            active   <= 1'b0;
            dir      <= 1'b0;
            step     <= 1'b0;
        end else begin
            state    <= state_n;
            slot_cnt <= slot_next;
            pos      <= pos_n;
            home_cnt <= home_n;
            active   <= active_n;
            dir      <= dir_n;
            step     <= step_n;
        end
    end

    always_comb begin
        state_n  = state;
        pos_n    = pos;
        home_n   = home_cnt;
        active_n = active;
        dir_n    = dir;

        // Position follows the falling edge of the pulse just emitted.
        if (slot_fall && active) begin
            if (state == HOME) begin
                home_n = home_cnt + 1'b1;
            end else if (dir && pos != POS_MAX) begin
                pos_n = pos + 1'b1;
            end else if (!dir && pos != '0) begin
                pos_n = pos - 1'b1;
            end
        end

        // Slot decisions land on the edge into slot clock 0, giving dir setup before the pulse.
        if (slot_last) begin
            active_n = 1'b0;
            case (state)
                HOME: begin
                    dir_n = 1'b0;
                    if (home_cnt < HOME_W'(HOME_STEPS)) begin
                        active_n = 1'b1;
                    end else begin
                        state_n = SETTLE;
                    end
                end
                SETTLE: begin
                    state_n = TRACK;
                    pos_n   = '0;
                    if (target != '0) begin
                        active_n = 1'b1;
                        dir_n    = 1'b1;
                    end
                end
                TRACK: begin
                    if (pos < target) begin
                        active_n = 1'b1;
                        dir_n    = 1'b1;
                    end else if (pos > target) begin
                        active_n = 1'b1;
                        dir_n    = 1'b0;
                    end
                end
                default: state_n = HOME;
            endcase
        end

        step_n = active_n && (slot_next != '0) && (slot_next <= SLOT_W'(HALF));
    end

    assign tracking  = (state == TRACK);
    assign state_dbg = state;

endmodule

// File: rtl/dashboard_gauge_driver.sv
// Samples engine and vehicle speed every millisecond, scales them to needle targets
// and drives the tachometer and speedometer steppers plus the shift light.
module dashboard_gauge_driver
  import gauge_pkg::*;
#(
    parameter int CLK_FREQ_HZ      = 50_000_000,
    parameter int STEPS_FULL       = STEPS_FULL_DEF,
    parameter int TACH_FULL_SCALE  = 8000,
    parameter int SPEED_FULL_SCALE = 320,
    parameter int STEP_CLKS        = 50_000,
    parameter int HOME_MARGIN      = 64,
    parameter int SHIFT_RPM        = 6500
) (
    input  logic                           clk,
    input  logic                           rst,
    dashboard_gauge_driver_if.slave        sensors,
    output logic                           tach_step,
    output logic                           tach_dir,
    output logic                           speed_step,
    output logic                           speed_dir,
    output logic                           shift_led,
    output logic                           gauges_ready,
    output axis_state_t                    tach_state,
    output axis_state_t                    speed_state
);

    localparam int TICK_CLKS = CLK_FREQ_HZ / 1000;
    localparam int TICK_W    = $clog2(TICK_CLKS);
    localparam logic [31:0] TACH_GAIN  = gain_q16(STEPS_FULL, TACH_FULL_SCALE);
    localparam logic [31:0] SPEED_GAIN = gain_q16(STEPS_FULL, SPEED_FULL_SCALE);

    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic [13:0]       rev_q;
    logic [8:0]        spd_q;
    logic [POS_W-1:0]  tach_target, speed_target;
    logic              tach_tracking, speed_tracking;

    // Rounded Q16 scaling; saturates at full deflection instead of wrapping.
    function automatic logic [POS_W-1:0] scale(input logic [31:0] val, input logic [31:0] gain);
        logic [31:0] prod;
        logic [31:0] rounded;
        prod    = val * gain;
        rounded = (prod + 32'h0000_8000) >> 16;
        if (rounded > 32'(STEPS_FULL - 1)) return POS_W'(STEPS_FULL - 1);
        return rounded[POS_W-1:0];
    endfunction

    assign tick = (tick_cnt == TICK_W'(TICK_CLKS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt  <= '0;
            rev_q     <= '0;
            spd_q     <= '0;
            shift_led <= 1'b0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (tick) begin
                rev_q     <= sensors.engine_rev;
                spd_q     <= sensors.vehicle_speed;
                shift_led <= (sensors.engine_rev >= 14'(SHIFT_RPM));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tach_target  <= '0;
            speed_target <= '0;
            gauges_ready <= 1'b0;
        end else begin
            tach_target  <= scale({18'd0, rev_q}, TACH_GAIN);
            speed_target <= scale({23'd0, spd_q}, SPEED_GAIN);
            gauges_ready <= tach_tracking & speed_tracking;
        end
    end

    gauge_axis #(
        .STEPS_FULL (STEPS_FULL),
        .STEP_CLKS  (STEP_CLKS),
        .HOME_MARGIN(HOME_MARGIN)
    ) u_tach (
        .clk      (clk),
        .rst      (rst),
        .target   (tach_target),
        .step     (tach_step),
        .dir      (tach_dir),
        .tracking (tach_tracking),
        .state_dbg(tach_state)
    );

    gauge_axis #(
        .STEPS_FULL (STEPS_FULL),
        .STEP_CLKS  (STEP_CLKS),
        .HOME_MARGIN(HOME_MARGIN)
    ) u_speed (
        .clk      (clk),
        .rst      (rst),
        .target   (speed_target),
        .step     (speed_step),
        .dir      (speed_dir),
        .tracking (speed_tracking),
        .state_dbg(speed_state)
    );

endmodule
